cla_multiword_add_ctrl: RTL and testbench

- Sequencer that performs a wide add/subtract by stepping one SLICE_W-bit carry-lookahead slice over NUM_SLICES cycles, least-significant slice first.
- Chains each slice's carry-out into the next slice's carry-in through a carry register.
- Sits between the ALU issue logic and the slice adder. Gives a start/busy/done handshake and registered result flags.

---
 rtl/cla_multiword_add_ctrl.sv | 99 +++++++++
 tb/tb_cla_multiword_add_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/cla_multiword_add_ctrl.sv
// Multi-cycle wide adder/subtractor: steps one SLICE_W-bit slice per cycle, LSB slice first,
// chaining the slice carry through a register and publishing registered result flags.
module cla_multiword_add_ctrl #(
  parameter int unsigned SLICE_W    = 16,
  parameter int unsigned NUM_SLICES = 4,
  localparam int unsigned W         = SLICE_W * NUM_SLICES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         ovf,
  output logic         zero
);

  localparam int unsigned IdxW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q;
  logic [W-1:0]      op_a_q, op_b_q, acc_q, sum_q;
  logic [IdxW-1:0]   idx_q;
  logic              carry_q, done_q, c_out_q, ovf_q, zero_q;

  logic [SLICE_W-1:0] a_sl, b_sl;
  logic [SLICE_W:0]   slice_sum;
  logic [W-1:0]       acc_d;
  logic               msb_cin, last_slice;

  always_comb begin
    a_sl       = op_a_q[idx_q*SLICE_W +: SLICE_W];
    b_sl       = op_b_q[idx_q*SLICE_W +: SLICE_W];
    slice_sum  = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE_W{1'b0}}, carry_q};
    // Carry into the word MSB, recovered from the MSB sum bit of the final slice.
    msb_cin    = a_sl[SLICE_W-1] ^ b_sl[SLICE_W-1] ^ slice_sum[SLICE_W-1];
    last_slice = (idx_q == IdxW'(NUM_SLICES - 1));
    acc_d      = acc_q;
    acc_d[idx_q*SLICE_W +: SLICE_W] = slice_sum[SLICE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_a_q  <= '0;
      op_b_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      done_q  <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            op_a_q  <= a;
            op_b_q  <= sub ? ~b : b;
            carry_q <= sub | c_in;
            idx_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          acc_q   <= acc_d;
          carry_q <= slice_sum[SLICE_W];
          idx_q   <= idx_q + IdxW'(1);
          if (last_slice) begin
            sum_q   <= acc_d;
            c_out_q <= slice_sum[SLICE_W];
            ovf_q   <= msb_cin ^ slice_sum[SLICE_W];
            zero_q  <= (acc_d == '0);
            done_q  <= 1'b1;
            idx_q   <= '0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy  = (state_q == StRun);
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_cla_multiword_add_ctrl.sv
// Randomized self-checking bench for cla_multiword_add_ctrl against a whole-word arithmetic model.
module tb_cla_multiword_add_ctrl;

  localparam int unsigned NS = 4;

  logic        clk = 1'b0;
  logic        rst, start, c_in, sub;
  logic [63:0] a, b;
  logic        busy, done, c_out, ovf, zero;
  logic [63:0] sum;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  logic [63:0] prev_sum = '0;

  always #5 clk = ~clk;

  cla_multiword_add_ctrl #(.SLICE_W(16), .NUM_SLICES(NS)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .c_out(c_out), .ovf(ovf), .zero(zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Whole-word reference: two's-complement add/subtract on a 65-bit integer.
  function automatic void model(input logic [63:0] ma, input logic [63:0] mb, input logic mc,
                                input logic ms, output logic [63:0] s, output logic co,
                                output logic ov, output logic z);
    logic [64:0] full;
    if (ms) full = {1'b0, ma} - {1'b0, mb} + 65'h1_0000_0000_0000_0000;
    else    full = {1'b0, ma} + {1'b0, mb} + {64'd0, mc};
    s  = full[63:0];
    co = full[64];
    if (ms) ov = (ma[63] != mb[63]) && (s[63] != ma[63]);
    else    ov = (ma[63] == mb[63]) && (s[63] != ma[63]);
    z  = (s == 64'd0);
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Issue one operation from the current (post-edge) point; poke_at >= 0 re-asserts start
  // with junk operands that many edges into the run.
  task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_v, input logic tc,
                        input logic ts, input int poke_at);
    logic [63:0] es;
    logic        eco, eov, ez;
    int          cyc;
    model(ta, tb_v, tc, ts, es, eco, eov, ez);
    a = ta; b = tb_v; c_in = tc; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = rnd64(); b = rnd64(); c_in = $urandom; sub = $urandom;
    cyc = 0;
    while (!done && cyc < 20) begin
      check("busy_run", {63'd0, busy}, 64'd1);
      check("sum_hold", sum, prev_sum);
      start = (cyc == poke_at);
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    check("latency", 64'(cyc), 64'(NS));
    check("busy_done", {63'd0, busy}, 64'd0);
    check("sum", sum, es);
    check("c_out", {63'd0, c_out}, {63'd0, eco});
    check("ovf", {63'd0, ovf}, {63'd0, eov});
    check("zero", {63'd0, zero}, {63'd0, ez});
    prev_sum = es;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    check("done_pulse", {63'd0, done}, 64'd0);
    check("busy_idle", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; a = '1; b = '1; c_in = 1'b1; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_sum", sum, 64'd0);
    check("rst_flags", {61'd0, c_out, ovf, zero}, 64'd0);
    rst = 1'b0; start = 1'b0;
    idle_cycle();

    run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, -1);
    check("dir_sum_carry", sum, 64'h0000_0000_0001_0000);
    idle_cycle();
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, -1);
    check("dir_ripple_zero", {63'd0, zero}, 64'd1);
    idle_cycle();
    run_op(64'd5, 64'd7, 1'b0, 1'b1, -1);
    check("dir_sub_neg", sum, 64'hFFFF_FFFF_FFFF_FFFE);
    idle_cycle();
    run_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, -1);
    check("dir_sub_ovf", {62'd0, c_out, ovf}, 64'd3);
    idle_cycle();
    // c_in must be ignored on subtract
    run_op(64'd5, 64'd7, 1'b1, 1'b1, -1);
    idle_cycle();
    // start re-asserted mid-run is ignored
    run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 2);
    idle_cycle();
    // start held through the done cycle: back-to-back with no gap
    run_op(rnd64(), rnd64(), 1'b1, 1'b0, -1);
    run_op(rnd64(), rnd64(), 1'b0, 1'b1, -1);
    idle_cycle();

    // reset at the second RUN edge aborts with no done pulse
    a = rnd64(); b = rnd64(); c_in = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_sum", sum, 64'd0);
    prev_sum = '0;
    for (int i = 0; i < NS + 1; i++) idle_cycle();
    run_op(64'h00FF_00FF_00FF_00FF, 64'hFF01_FF01_FF01_FF01, 1'b0, 1'b0, -1);
    idle_cycle();

    for (int i = 0; i < 30; i++) begin
      logic [63:0] ra, rb;
      ra = rnd64();
      rb = rnd64();
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ~ra;
        default: ;
      endcase
      run_op(ra, rb, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? 1 : -1);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
